// File: rtl/bitwise_pipe.sv
// Pipelined eight-op bitwise unit with zr/ng flags and a delivered-result counter.
// Latency STAGES cycles, one result per cycle. in_ready drops only when every stage is full and out_ready is low.
module bitwise_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zr,
    output logic             out_ng,
    output logic [CNT_W-1:0] op_count
);

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic             zr;
        logic             ng;
    } res_t;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] ld;
    logic [STAGES:0]   vsrc;
    res_t              stg [STAGES];
    res_t              src [STAGES+1];
    res_t              ent;
    logic              all_full;

    always_comb begin
        ent.dat = '0;
        case (in_op)
            3'b000: ent.dat = ~in_a;
            3'b001: ent.dat = in_a & in_b;
            3'b010: ent.dat = in_a | in_b;
            3'b011: ent.dat = in_a ^ in_b;
            3'b100: ent.dat = ~(in_a & in_b);
            3'b101: ent.dat = ~(in_a | in_b);
            3'b110: ent.dat = ~(in_a ^ in_b);
            default: ent.dat = in_a;
        endcase
        ent.zr = (ent.dat == '0);
        ent.ng = ent.dat[WIDTH-1];
    end

    // Stage k may load when out_ready is high or any stage at or after k is empty,
    // which is the unrolled form of "empty or successor loads".
    always_comb begin
        ld       = '0;
        all_full = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            all_full = all_full & vld[k];
            ld[k]    = out_ready | ~all_full;
        end
    end

    assign in_ready = ld[0];

    always_comb begin
        vsrc   = {vld, in_valid};
        src[0] = ent;
        for (int k = 0; k < STAGES; k++) begin
            src[k+1] = stg[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    vld[k] <= vsrc[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (ld[k] && vsrc[k]) begin
                stg[k] <= src[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_count <= '0;
        end else if (vld[STAGES-1] && out_ready) begin
            op_count <= op_count + 1'b1;
        end
    end

    assign out_valid = vld[STAGES-1];
    assign out_data  = out_valid ? stg[STAGES-1].dat : '0;
    assign out_zr    = out_valid & stg[STAGES-1].zr;
    assign out_ng    = out_valid & stg[STAGES-1].ng;

endmodule

// File: tb/tb_bitwise_pipe.sv
// Directed and scoreboard bench for bitwise_pipe in three shapes: (8,1,4), (16,2,16), (32,4,16).
module tb_bitwise_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  in_op = 3'b0;
    logic [31:0] a32 = 32'h0;
    logic [31:0] b32 = 32'h0;

    always #5 clk = ~clk;

    logic        ir0, ov0, zr0, ng0;
    logic [7:0]  od0;
    logic [3:0]  c0;
    logic        ir1, ov1, zr1, ng1;
    logic [15:0] od1;
    logic [15:0] c1;
    logic        ir2, ov2, zr2, ng2;
    logic [31:0] od2;
    logic [15:0] c2;

    bitwise_pipe #(.WIDTH(8), .STAGES(1), .CNT_W(4)) u_s1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0),
        .in_a(a32[7:0]), .in_b(b32[7:0]), .in_op(in_op),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .out_zr(zr0), .out_ng(ng0), .op_count(c0));

    bitwise_pipe #(.WIDTH(16), .STAGES(2), .CNT_W(16)) u_s2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
        .in_a(a32[15:0]), .in_b(b32[15:0]), .in_op(in_op),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .out_zr(zr1), .out_ng(ng1), .op_count(c1));

    bitwise_pipe #(.WIDTH(32), .STAGES(4), .CNT_W(16)) u_s4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2),
        .in_a(a32), .in_b(b32), .in_op(in_op),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
        .out_zr(zr2), .out_ng(ng2), .op_count(c2));

    localparam int W [3] = '{8, 16, 32};
    localparam int S [3] = '{1, 2, 4};

    logic        ir [3];
    logic        ov [3];
    logic        zr [3];
    logic        ng [3];
    logic [31:0] od [3];
    logic [31:0] cnt [3];

    always_comb begin
        ir[0] = ir0;  ir[1] = ir1;  ir[2] = ir2;
        ov[0] = ov0;  ov[1] = ov1;  ov[2] = ov2;
        zr[0] = zr0;  zr[1] = zr1;  zr[2] = zr2;
        ng[0] = ng0;  ng[1] = ng1;  ng[2] = ng2;
        od[0] = {24'b0, od0};
        od[1] = {16'b0, od1};
        od[2] = od2;
        cnt[0] = {28'b0, c0};
        cnt[1] = {16'b0, c1};
        cnt[2] = {16'b0, c2};
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input int w);
        logic [31:0] r;
        logic [31:0] m;
        case (op)
            3'd0: r = ~a;
            3'd1: r = a & b;
            3'd2: r = a | b;
            3'd3: r = a ^ b;
            3'd4: r = ~(a & b);
            3'd5: r = ~(a | b);
            3'd6: r = ~(a ^ b);
            default: r = a;
        endcase
        m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return r & m;
    endfunction

    // Scoreboard per DUT: push the model result on each input transfer, pop on each output transfer.
    logic [31:0] q [3][$];
    int          dlv [3];
    int          acc [3];
    logic        held_v [3];
    logic [31:0] held_d [3];
    logic [31:0] mon_e;

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                q[d].delete();
                dlv[d] = 0;
                acc[d] = 0;
                held_v[d] = 1'b0;
            end else begin
                if (held_v[d]) begin
                    chk($sformatf("hold_valid_d%0d", d), 32'(ov[d]), 32'd1);
                    chk($sformatf("hold_data_d%0d", d), od[d], held_d[d]);
                end
                held_v[d] = ov[d] && !out_ready;
                held_d[d] = od[d];
                if (!ov[d]) begin
                    chk($sformatf("idle_gate_d%0d", d), od[d] | {30'b0, zr[d], ng[d]}, 32'd0);
                end
                if (ov[d] && out_ready) begin
                    dlv[d]++;
                    if (q[d].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_extra_d%0d: got result %0h want none", d, od[d]);
                    end else begin
                        mon_e = q[d].pop_front();
                        chk($sformatf("sb_data_d%0d", d), od[d], mon_e);
                        chk($sformatf("sb_zr_d%0d", d), 32'(zr[d]), 32'(mon_e == 32'd0));
                        chk($sformatf("sb_ng_d%0d", d), 32'(ng[d]), 32'(mon_e[W[d]-1]));
                    end
                end
                if (in_valid && ir[d]) begin
                    q[d].push_back(ref_op(in_op, a32, b32, W[d]));
                    acc[d]++;
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        in_op    = op;
        a32      = a;
        b32      = b;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 60) begin
            @(posedge clk);
            #1 n++;
        end
        chk({nm, "_drain_in_time"}, 32'(n < 60), 32'd1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic        zr;
        logic        ng;
    } vec_t;

    vec_t        tv [11];
    logic [31:0] its [4];
    int          lat [3];
    logic        seen [3];
    int          idx, stalls, stale, n, guard;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{3'b000, 16'hA5A5, 16'h0000, 16'h5A5A, 1'b0, 1'b0};
        tv[1]  = '{3'b000, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b1};
        tv[2]  = '{3'b000, 16'hF0F0, 16'hFF00, 16'h0F0F, 1'b0, 1'b0};
        tv[3]  = '{3'b001, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b1};
        tv[4]  = '{3'b010, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 1'b1};
        tv[5]  = '{3'b011, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0};
        tv[6]  = '{3'b100, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0, 1'b0};
        tv[7]  = '{3'b101, 16'hF0F0, 16'hFF00, 16'h000F, 1'b0, 1'b0};
        tv[8]  = '{3'b110, 16'hF0F0, 16'hFF00, 16'hF00F, 1'b0, 1'b1};
        tv[9]  = '{3'b111, 16'hF0F0, 16'hFF00, 16'hF0F0, 1'b0, 1'b1};
        tv[10] = '{3'b001, 16'h00FF, 16'hFF00, 16'h0000, 1'b1, 1'b0};
        its[0] = 32'h0000_1234;
        its[1] = 32'h0000_5678;
        its[2] = 32'h0000_9ABC;
        its[3] = 32'h0000_DEF0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_valid_d%0d", d), 32'(ov[d]), 32'd0);
            chk($sformatf("rst_data_d%0d", d), od[d], 32'd0);
            chk($sformatf("rst_count_d%0d", d), cnt[d], 32'd0);
            chk($sformatf("rst_in_ready_d%0d", d), 32'(ir[d]), 32'd1);
        end

        // Single-op vectors: latency per shape and hand-computed results on the 16-bit unit
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1 drive(1'b1, tv[i].op, {16'h0, tv[i].a}, {16'h0, tv[i].b});
            @(posedge clk);
            #1 in_valid = 1'b0;
            for (int d = 0; d < 3; d++) begin
                seen[d] = 1'b0;
                lat[d] = 0;
            end
            for (int step = 1; step <= 5; step++) begin
                for (int d = 0; d < 3; d++) begin
                    if (!seen[d] && ov[d]) begin
                        seen[d] = 1'b1;
                        lat[d] = step;
                        if (d == 1) begin
                            chk($sformatf("vec%0d_data", i), od[1], {16'h0, tv[i].d});
                            chk($sformatf("vec%0d_zr", i), 32'(zr[1]), 32'(tv[i].zr));
                            chk($sformatf("vec%0d_ng", i), 32'(ng[1]), 32'(tv[i].ng));
                        end
                    end
                end
                @(posedge clk);
                #1;
            end
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("vec%0d_latency_d%0d", i, d), 32'(lat[d]), 32'(S[d]));
            end
        end

        // Backpressure: fill while stalled, then release
        do_reset();
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1 drive(idx < 4, 3'b011, its[idx & 3], 32'h0000_FFFF);
            #1 if (in_valid && ir[1]) idx++;
        end
        @(posedge clk);
        #2;
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_in_ready_full", 32'(ir[1]), 32'd0);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("bp_capacity_d%0d", d), 32'(acc[d]), 32'(S[d]));
            chk($sformatf("bp_valid_d%0d", d), 32'(ov[d]), 32'd1);
        end
        chk("bp_head_d0", od[0], 32'h0000_00CB);
        chk("bp_head_d1", od[1], 32'h0000_EDCB);
        chk("bp_head_d2", od[2], 32'h0000_EDCB);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1 drive(idx < 4, 3'b011, its[idx & 3], 32'h0000_FFFF);
            out_ready = 1'b1;
            #1 chk($sformatf("bp_nogap_%0d", c), 32'(ov[1]), 32'd1);
            if (in_valid && ir[1]) idx++;
        end
        drain("bp");
        chk("bp_all_in", 32'(idx), 32'd4);
        chk("bp_delivered", 32'(dlv[1]), 32'd4);

        // Back-to-back random ops, full throughput
        do_reset();
        out_ready = 1'b1;
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1 drive(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
            #1 if (!(ir[0] && ir[1] && ir[2])) stalls++;
        end
        drain("b2b");
        chk("b2b_stalls", 32'(stalls), 32'd0);
        chk("b2b_count_d0", cnt[0], 32'd4);
        chk("b2b_count_d1", cnt[1], 32'd100);
        chk("b2b_count_d2", cnt[2], 32'd100);
        chk("b2b_accepted_d2", 32'(acc[2]), 32'd100);

        // Random out_ready toggling
        n = 0;
        guard = 0;
        while (n < 100 && guard < 2000) begin
            @(posedge clk);
            #1 out_ready = 1'($urandom_range(0, 1));
            drive(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
            #1 if (ir[1]) n++;
            guard++;
        end
        chk("rnd_in_time", 32'(guard < 2000), 32'd1);
        drain("rnd");
        chk("rnd_count_d1", cnt[1], 32'd200);
        chk("rnd_count_d0", cnt[0], 32'(dlv[0] % 16));
        chk("rnd_count_d2", cnt[2], 32'(dlv[2]));

        // Reset while full and stalled
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 drive(1'b1, 3'b000, 32'h1111 * (i + 1), 32'h0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("midrst_valid_d%0d", d), 32'(ov[d]), 32'd0);
            chk($sformatf("midrst_data_d%0d", d), od[d], 32'd0);
            chk($sformatf("midrst_count_d%0d", d), cnt[d], 32'd0);
            chk($sformatf("midrst_in_ready_d%0d", d), 32'(ir[d]), 32'd1);
        end
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1 if (ov[0] || ov[1] || ov[2]) stale++;
        end
        chk("midrst_no_stale", 32'(stale), 32'd0);

        // Counter wrap on the 4-bit counter
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1 drive(1'b1, 3'b111, 32'(i), 32'h0);
        end
        drain("wrap");
        chk("wrap_count_d0", cnt[0], 32'd1);
        chk("wrap_count_d1", cnt[1], 32'd17);
        chk("wrap_count_d2", cnt[2], 32'd17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
